// File: rtl/mux_4to1_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_4to1_scanner_if
// Brief    : Word handshake, mux drive/return and serial result bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_4to1_scanner_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [3:0]       mux_i;
    logic [1:0]       mux_s;
    logic             mux_y;
    logic             ser_bit;
    logic             ser_valid;
    logic             done;
    logic             word_ok;
    logic [CNT_W-1:0] err_cnt;

    // Upstream producer plus the mux under test.
    modport master (
        output in_valid, in_data, mux_y,
        input  in_ready, mux_i, mux_s, ser_bit, ser_valid, done, word_ok, err_cnt
    );

    // The scanner itself.
    modport slave (
        input  in_valid, in_data, mux_y,
        output in_ready, mux_i, mux_s, ser_bit, ser_valid, done, word_ok, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mux_4to1_scanner.sv
`default_nettype none
// ============================================================================
// Module   : mux_4to1_scanner
// Brief    : Drives a 4:1 mux with an accepted word, scans every select and
//            serialises/self-checks the mux output.
// Revision : 1.0 - initial release
// ============================================================================
module mux_4to1_scanner #(
    parameter int HOLD_CYCLES = 1,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int CNT_W       = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mux_4to1_scanner_if.slave bus
);

    localparam logic [1:0]       c_ST_IDLE    = 2'd0;
    localparam logic [1:0]       c_ST_SCAN    = 2'd1;
    localparam logic [1:0]       c_ST_DONE    = 2'd2;
    localparam logic [7:0]       c_HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [1:0]       c_SEL_FIRST  = LSB_FIRST ? 2'd0 : 2'd3;
    localparam logic [1:0]       c_SEL_LAST   = LSB_FIRST ? 2'd3 : 2'd0;
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_sample;
    logic             w_last;
    logic [3:0]       w_word;
    logic             w_mismatch;

    logic [3:0]       r_mux_i;
    logic [1:0]       r_mux_s;
    logic [7:0]       r_hold;
    logic [3:0]       r_cap;
    logic             r_ser_bit;
    logic             r_ser_valid;
    logic             r_done;
    logic             r_word_ok;
    logic [CNT_W-1:0] r_err_cnt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_SCAN;
                end
            end
            c_ST_SCAN: begin
                if (w_sample && w_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and per-cycle decodes
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready = (r_state == c_ST_IDLE) && rst_n;
        w_accept   = w_in_ready && bus.in_valid;
        w_sample   = (r_state == c_ST_SCAN) && (r_hold == c_HOLD_LAST);
        w_last     = (r_mux_s == c_SEL_LAST);
        // Rebuilt word includes the bit being sampled on this edge.
        w_word           = r_cap;
        w_word[r_mux_s]  = bus.mux_y;
        w_mismatch       = (w_word != r_mux_i);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mux_i     <= 4'd0;
            r_mux_s     <= 2'd0;
            r_hold      <= 8'd0;
            r_cap       <= 4'd0;
            r_ser_bit   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b0;
            r_word_ok   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_ser_valid <= 1'b0;
            r_done      <= 1'b0;
            if (w_accept) begin
                r_mux_i <= bus.in_data;
                r_mux_s <= c_SEL_FIRST;
                r_hold  <= 8'd0;
                r_cap   <= 4'd0;
            end else if (r_state == c_ST_SCAN) begin
                if (!w_sample) begin
                    r_hold <= r_hold + 8'd1;
                end else begin
                    r_hold      <= 8'd0;
                    r_ser_bit   <= bus.mux_y;
                    r_ser_valid <= 1'b1;
                    r_cap       <= w_word;
                    if (!w_last) begin
                        r_mux_s <= LSB_FIRST ? (r_mux_s + 2'd1) : (r_mux_s - 2'd1);
                    end else begin
                        r_done    <= 1'b1;
                        r_word_ok <= !w_mismatch;
                        if (w_mismatch && (r_err_cnt != c_CNT_MAX)) begin
                            r_err_cnt <= r_err_cnt + c_CNT_ONE;
                        end
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mux_i     = r_mux_i;
    assign bus.mux_s     = r_mux_s;
    assign bus.ser_bit   = r_ser_bit;
    assign bus.ser_valid = r_ser_valid;
    assign bus.done      = r_done;
    assign bus.word_ok   = r_word_ok;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_4to1_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4to1_scanner
// Brief    : Directed self-checking bench for three scanner configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_4to1_scanner;

    logic clk;
    logic rst_n;
    logic fault_b;
    logic glitch_c;
    int   n_checks;
    int   n_fail;

    mux_4to1_scanner_if #(.CNT_W(8)) ifa ();
    mux_4to1_scanner_if #(.CNT_W(2)) ifb ();
    mux_4to1_scanner_if #(.CNT_W(8)) ifc ();

    mux_4to1_scanner #(.HOLD_CYCLES(1), .LSB_FIRST(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    mux_4to1_scanner #(.HOLD_CYCLES(1), .LSB_FIRST(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );
    mux_4to1_scanner #(.HOLD_CYCLES(3), .LSB_FIRST(1'b1), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
    );

    // Mux models: ideal, ideal-or-stuck-at-0, ideal with injected glitches.
    assign ifa.mux_y = ifa.mux_i[ifa.mux_s];
    assign ifb.mux_y = fault_b ? 1'b0 : ifb.mux_i[ifb.mux_s];
    assign ifc.mux_y = ifc.mux_i[ifc.mux_s] ^ glitch_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One word through dut_b; consumes exactly six clocks starting with the accept.
    task automatic run_b(input logic [3:0] data, output logic [3:0] bits,
                         output logic ok, output int nvalid);
        ifb.in_data  = data;
        ifb.in_valid = 1'b1;
        check("b_ready_before", ifb.in_ready, 1);
        tick;
        check("b_ready_low", ifb.in_ready, 0);
        nvalid = 0;
        bits   = 4'd0;
        for (int j = 0; j < 4; j++) begin
            tick;
            if (ifb.ser_valid) nvalid++;
            bits[3-j] = ifb.ser_bit;
        end
        check("b_done", ifb.done, 1);
        ok = ifb.word_ok;
        tick;
        check("b_done_clear", ifb.done, 0);
        check("b_ready_back", ifb.in_ready, 1);
    endtask

    initial begin
        logic [3:0] bits;
        logic [3:0] d;
        logic       ok;
        int         nv;
        int         seen;

        n_checks     = 0;
        n_fail       = 0;
        fault_b      = 1'b0;
        glitch_c     = 1'b0;
        rst_n        = 1'b0;
        ifa.in_valid = 1'b1; ifa.in_data = 4'hA;
        ifb.in_valid = 1'b1; ifb.in_data = 4'h5;
        ifc.in_valid = 1'b1; ifc.in_data = 4'h3;

        // Reset with in_valid asserted
        repeat (3) tick;
        check("rst_in_ready", ifa.in_ready, 0);
        check("rst_mux_i", ifa.mux_i, 0);
        check("rst_mux_s", ifa.mux_s, 0);
        check("rst_ser_bit", ifa.ser_bit, 0);
        check("rst_ser_valid", ifa.ser_valid, 0);
        check("rst_done", ifa.done, 0);
        check("rst_word_ok", ifa.word_ok, 0);
        check("rst_err_cnt", ifa.err_cnt, 0);
        check("rst_c_ready", ifc.in_ready, 0);
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
        ifc.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick;
        check("rel_in_ready", ifa.in_ready, 1);
        check("rel_no_accept", ifa.mux_i, 0);

        // Loopback, LSB first, word 1010
        d            = 4'b1010;
        ifa.in_data  = d;
        ifa.in_valid = 1'b1;
        tick;
        ifa.in_valid = 1'b0;
        check("a_mux_i", ifa.mux_i, 4'hA);
        for (int j = 0; j < 4; j++) begin
            check("a_mux_s", ifa.mux_s, j);
            check("a_ready_low", ifa.in_ready, 0);
            tick;
            check("a_ser_valid", ifa.ser_valid, 1);
            check("a_ser_bit", ifa.ser_bit, d[j]);
        end
        check("a_done", ifa.done, 1);
        check("a_word_ok", ifa.word_ok, 1);
        check("a_err_cnt", ifa.err_cnt, 0);
        check("a_ready_in_done", ifa.in_ready, 0);
        tick;
        check("a_done_clear", ifa.done, 0);
        check("a_sv_clear", ifa.ser_valid, 0);
        check("a_ready_back", ifa.in_ready, 1);
        check("a_mux_i_hold", ifa.mux_i, 4'hA);
        check("a_mux_s_hold", ifa.mux_s, 3);

        // Back-to-back sweep of all words, MSB first
        for (int w = 0; w < 16; w++) begin
            run_b(4'(w), bits, ok, nv);
            check("b_bits", bits, w);
            check("b_word_ok", ok, 1);
            check("b_nvalid", nv, 4);
        end
        check("b_err_after_sweep", ifb.err_cnt, 0);

        // Stuck-at-0 mux, saturating two-bit counter
        fault_b = 1'b1;
        run_b(4'hF, bits, ok, nv);
        check("f_bits", bits, 0);
        check("f_word_ok", ok, 0);
        check("f_err_1", ifb.err_cnt, 1);
        run_b(4'hF, bits, ok, nv);
        check("f_err_2", ifb.err_cnt, 2);
        for (int i = 0; i < 3; i++) run_b(4'hF, bits, ok, nv);
        check("f_err_sat", ifb.err_cnt, 3);
        ifb.in_valid = 1'b0;
        fault_b      = 1'b0;

        // HOLD_CYCLES=3 with glitches before non-sample edges
        d            = 4'b0110;
        ifc.in_data  = d;
        ifc.in_valid = 1'b1;
        tick;
        ifc.in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            glitch_c = 1'b1;
            check("c_mux_s0", ifc.mux_s, j);
            tick;
            check("c_sv_hold1", ifc.ser_valid, 0);
            check("c_mux_s1", ifc.mux_s, j);
            tick;
            glitch_c = 1'b0;
            check("c_sv_hold2", ifc.ser_valid, 0);
            check("c_mux_s2", ifc.mux_s, j);
            check("c_done_early", ifc.done, 0);
            tick;
            check("c_ser_valid", ifc.ser_valid, 1);
            check("c_ser_bit", ifc.ser_bit, d[j]);
        end
        check("c_done", ifc.done, 1);
        check("c_word_ok", ifc.word_ok, 1);
        check("c_err_cnt", ifc.err_cnt, 0);
        tick;

        // Reset during the second channel of a scan
        ifa.in_data  = 4'b0101;
        ifa.in_valid = 1'b1;
        tick;
        ifa.in_valid = 1'b0;
        tick;
        check("r_mux_s_ch1", ifa.mux_s, 1);
        rst_n = 1'b0;
        tick;
        check("r_sv_in_rst", ifa.ser_valid, 0);
        check("r_done_in_rst", ifa.done, 0);
        check("r_ready_in_rst", ifa.in_ready, 0);
        rst_n = 1'b1;
        tick;
        check("r_ready_after", ifa.in_ready, 1);
        check("r_err_a", ifa.err_cnt, 0);
        check("r_err_b", ifb.err_cnt, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifa.ser_valid || ifa.done) seen++;
            tick;
        end
        check("r_no_activity", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
